// File: rtl/csa42_accum.sv
// Multi-beat carry-save accumulator: each beat's four rows are folded through two
// 4:2 compressor levels into a redundant (sum, carry) pair, resolved once per operation.
module csa42_accum #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p0,
  input  logic [WIDTH-1:0] in_p1,
  input  logic [WIDTH-1:0] in_p2,
  input  logic [WIDTH-1:0] in_p3,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_s,
  output logic [WIDTH-1:0] out_c,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_trunc
);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, OUT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
  } row_t;

  // One 4:2 compressor row; the lateral carry never depends on the incoming one,
  // so the chain is only one cell deep. The carry out of the MSB is dropped.
  function automatic row_t row42(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    row_t r;
    logic t;
    logic ci;
    logic co;
    ci = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      t      = a[i] ^ b[i] ^ c[i];
      co     = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      r.s[i] = t ^ d[i] ^ ci;
      r.c[i] = (t & d[i]) | (t & ci) | (d[i] & ci);
      ci     = co;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_s_q, acc_s_d;
  logic [WIDTH-1:0] acc_c_q, acc_c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [WIDTH-1:0] out_s_q, out_s_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             out_trunc_q, out_trunc_d;

  row_t             lvl1;
  row_t             lvl2;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_sum   = out_sum_q;
  assign out_s     = out_s_q;
  assign out_c     = out_c_q;
  assign out_beats = out_beats_q;
  assign out_trunc = out_trunc_q;

  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    cnt_d       = cnt_q;
    trunc_d     = trunc_q;
    out_sum_d   = out_sum_q;
    out_s_d     = out_s_q;
    out_c_d     = out_c_q;
    out_beats_d = out_beats_q;
    out_trunc_d = out_trunc_q;

    lvl1    = row42(in_p0, in_p1, in_p2, in_p3);
    lvl2    = row42(lvl1.s, {lvl1.c[WIDTH-2:0], 1'b0}, acc_s_q, {acc_c_q[WIDTH-2:0], 1'b0});
    cnt_inc = cnt_q + CNT_W'(1);
    accept  = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_s_d = lvl2.s;
          acc_c_d = lvl2.c;
          cnt_d   = CNT_W'(1);
          trunc_d = !in_last && (MAX_BEATS == 1);
          state_d = (in_last || MAX_BEATS == 1) ? RESOLVE : ACC;
        end
      end
      ACC: begin
        // A final beat that also fills the counter counts as a normal end.
        if (accept) begin
          acc_s_d = lvl2.s;
          acc_c_d = lvl2.c;
          cnt_d   = cnt_inc;
          if (in_last) begin
            state_d = RESOLVE;
          end else if (cnt_inc == CNT_W'(MAX_BEATS)) begin
            trunc_d = 1'b1;
            state_d = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        out_sum_d   = acc_s_q + {acc_c_q[WIDTH-2:0], 1'b0};
        out_s_d     = acc_s_q;
        out_c_d     = acc_c_q;
        out_beats_d = cnt_q;
        out_trunc_d = trunc_q;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          acc_s_d = '0;
          acc_c_d = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      out_sum_q   <= '0;
      out_s_q     <= '0;
      out_c_q     <= '0;
      out_beats_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      out_sum_q   <= out_sum_d;
      out_s_q     <= out_s_d;
      out_c_q     <= out_c_d;
      out_beats_q <= out_beats_d;
      out_trunc_q <= out_trunc_d;
    end
  end

endmodule

// File: tb/tb_csa42_accum.sv
// Bench for csa42_accum: directed tests on an 8-bit/4-beat instance and a random
// scoreboard run on a 32-bit/16-beat instance.
module tb_csa42_accum;

  logic clk;
  logic rst_n;

  logic       v8, r8, last8, ov8, or8, trunc8;
  logic [7:0] p80, p81, p82, p83, sum8, s8, c8;
  logic [2:0] beats8;

  logic        v32, r32, last32, ov32, or32, trunc32;
  logic [31:0] p320, p321, p322, p323, sum32, s32, c32;
  logic [4:0]  beats32;

  csa42_accum #(.WIDTH(8), .MAX_BEATS(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .in_p0(p80), .in_p1(p81), .in_p2(p82), .in_p3(p83), .in_last(last8),
    .out_valid(ov8), .out_ready(or8), .out_sum(sum8), .out_s(s8), .out_c(c8),
    .out_beats(beats8), .out_trunc(trunc8)
  );

  csa42_accum #(.WIDTH(32), .MAX_BEATS(16)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_p0(p320), .in_p1(p321), .in_p2(p322), .in_p3(p323), .in_last(last32),
    .out_valid(ov32), .out_ready(or32), .out_sum(sum32), .out_s(s32), .out_c(c32),
    .out_beats(beats32), .out_trunc(trunc32)
  );

  typedef struct {
    logic [31:0] sum;
    int          beats;
    logic        trunc;
  } exp_t;

  exp_t        q8[$];
  exp_t        q32[$];
  exp_t        e8, e32;
  logic [7:0]  tot8;
  int          nb8;
  logic [31:0] tot32;
  int          nb32;
  int          checks;
  int          errors;
  logic        random_phase;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic last);
    exp_t e;
    tot8 = tot8 + a + b + c + d;
    nb8++;
    if (last || nb8 == 4) begin
      e.sum = {24'd0, tot8};
      e.beats = nb8;
      e.trunc = !last;
      q8.push_back(e);
      tot8 = '0;
      nb8 = 0;
    end
  endtask

  task automatic model32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic last);
    exp_t e;
    tot32 = tot32 + a + b + c + d;
    nb32++;
    if (last || nb32 == 16) begin
      e.sum = tot32;
      e.beats = nb32;
      e.trunc = !last;
      q32.push_back(e);
      tot32 = '0;
      nb32 = 0;
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d, input logic last);
    logic acc;
    int guard;
    v8 = 1'b1; p80 = a; p81 = b; p82 = c; p83 = d; last8 = last;
    guard = 0;
    do begin
      acc = r8;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 50);
    v8 = 1'b0; last8 = 1'b0;
    if (!acc) checkOutput("accept8_timeout", {63'd0, acc}, 64'd1);
    else model8(a, b, c, d, last);
  endtask

  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                 input logic [31:0] d, input logic last);
    logic acc;
    int guard;
    v32 = 1'b1; p320 = a; p321 = b; p322 = c; p323 = d; last32 = last;
    guard = 0;
    do begin
      acc = r32;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    v32 = 1'b0; last32 = 1'b0;
    if (!acc) checkOutput("accept32_timeout", {63'd0, acc}, 64'd1);
    else model32(a, b, c, d, last);
  endtask

  task automatic drain8();
    int g;
    g = 0;
    while (q8.size() != 0 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    checkOutput("drain8_pending", 64'(q8.size()), 64'd0);
  endtask

  task automatic drain32();
    int g;
    g = 0;
    while (q32.size() != 0 && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    checkOutput("drain32_pending", 64'(q32.size()), 64'd0);
  endtask

  // Scoreboard pops on the cycle a result handshake is about to happen.
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        checkOutput("sb8_pending", {63'd0, q8.size() > 0}, 64'd1);
      end else begin
        e8 = q8.pop_front();
        checkOutput("sum8", {56'd0, sum8}, {32'd0, e8.sum});
        checkOutput("redundant8", {56'd0, 8'(s8 + {c8[6:0], 1'b0})}, {32'd0, e8.sum});
        checkOutput("beats8", {61'd0, beats8}, 64'(e8.beats));
        checkOutput("trunc8", {63'd0, trunc8}, {63'd0, e8.trunc});
      end
    end
    if (rst_n && ov32 && or32) begin
      if (q32.size() == 0) begin
        checkOutput("sb32_pending", {63'd0, q32.size() > 0}, 64'd1);
      end else begin
        e32 = q32.pop_front();
        checkOutput("sum32", {32'd0, sum32}, {32'd0, e32.sum});
        checkOutput("redundant32", {32'd0, s32 + {c32[30:0], 1'b0}}, {32'd0, e32.sum});
        checkOutput("beats32", {59'd0, beats32}, 64'(e32.beats));
        checkOutput("trunc32", {63'd0, trunc32}, {63'd0, e32.trunc});
      end
    end
  end

  initial begin
    or32 = 1'b1;
    @(posedge clk); #1;
    while (!random_phase) begin
      @(posedge clk); #1;
    end
    forever begin
      or32 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  end

  initial begin
    int lat;
    int n;
    int gap;
    checks = 0; errors = 0;
    tot8 = '0; nb8 = 0; tot32 = '0; nb32 = 0;
    random_phase = 1'b0;
    v8 = 0; last8 = 0; p80 = 0; p81 = 0; p82 = 0; p83 = 0; or8 = 1'b1;
    v32 = 0; last32 = 0; p320 = 0; p321 = 0; p322 = 0; p323 = 0;
    rst_n = 1'b0;

    #2;
    checkOutput("rst_out_valid", {63'd0, ov8}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, r8}, 64'd1);
    checkOutput("rst_out_sum", {56'd0, sum8}, 64'd0);
    checkOutput("rst_out_beats", {61'd0, beats8}, 64'd0);
    checkOutput("rst_out_trunc", {63'd0, trunc8}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat and its latency
    applyStimulus8(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov8 && lat < 10);
    checkOutput("latency", 64'(lat), 64'd2);
    @(posedge clk); #1;
    drain8();

    // Modular wrap
    applyStimulus8(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    applyStimulus8(8'h01, 8'h01, 8'h01, 8'h01, 1'b1);
    drain8();

    // Backpressure in OUT
    or8 = 1'b0;
    applyStimulus8(8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
    lat = 0;
    while (!ov8 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", {63'd0, ov8}, 64'd1);
      checkOutput("hold_in_ready", {63'd0, r8}, 64'd0);
      checkOutput("hold_sum", {56'd0, sum8}, 64'd26);
      checkOutput("hold_redundant", {56'd0, 8'(s8 + {c8[6:0], 1'b0})}, 64'd26);
      @(posedge clk); #1;
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", {63'd0, r8}, 64'd1);
    checkOutput("release_valid", {63'd0, ov8}, 64'd0);
    drain8();

    // Truncation at MAX_BEATS, fifth beat opens a new operation
    for (int i = 0; i < 5; i++) applyStimulus8(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    applyStimulus8(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    drain8();

    // in_last on the beat that fills the counter ends normally
    for (int i = 1; i <= 4; i++)
      applyStimulus8(8'(i), 8'(i), 8'(i), 8'(i), i == 4);
    drain8();

    // Reset in the middle of an operation
    for (int i = 0; i < 3; i++) applyStimulus8(8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    tot8 = '0; nb8 = 0;
    #1;
    checkOutput("midrst_valid", {63'd0, ov8}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, r8}, 64'd1);
    checkOutput("midrst_sum", {56'd0, sum8}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus8(8'd2, 8'd0, 8'd0, 8'd0, 1'b1);
    drain8();

    // Random operations on the 32-bit instance
    random_phase = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      n = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(1, 6));
      for (int b = 0; b < n; b++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk); #1;
        end
        applyStimulus32($urandom, $urandom, $urandom, $urandom, b == n - 1);
      end
    end
    drain32();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
